rv32i_uart_boot_loader: RTL and testbench
=========================================

// Module: rv32i_uart_boot_loader
// PURPOSE
//  Receives a program image over a UART (8N1) and writes it word-by-word into the
//  instruction/data RAM write port before the pipeline runs. Holds the core in reset
//  (core_hold) until a complete image with a valid checksum is loaded. Sits upstream
//  of the core top: its outputs drive the RAM write port and gate the core reset.
// PARAMETERS
//  CLKS_PER_BIT  87   clk cycles per UART bit (10 MHz / 115200); must be >= 4
//  ADDR_W        10   RAM word-address width; image capacity = 2**ADDR_W words
// PORTS
//  clk        in   1       system clock, single clock domain
//  reset      in   1       synchronous, active-high
//  uart_rx    in   1       asynchronous serial input, idle high
//  ram_we     out  1       one-cycle write strobe to RAM
//  ram_addr   out  ADDR_W  word address of write (byte address >> 2)
//  ram_wdata  out  32      little-endian assembled word
//  core_hold  out  1       1 = keep core in reset; combine with core reset upstream
//  boot_done  out  1       image loaded and checksum matched (sticky)
//  boot_err   out  1       framing/length/checksum error (sticky until reset)
// BEHAVIOUR
//  Reset: ram_we=0, ram_addr=0, ram_wdata=0, core_hold=1, boot_done=0, boot_err=0;
//   RX and loader FSMs to IDLE/LEN_LO, byte/word counters and checksum cleared.
//  RX: uart_rx through 2-flop synchroniser. RX FSM IDLE->START->DATA->STOP->IDLE.
//   IDLE: on synced 1->0 start START, counter=0. START: at CLKS_PER_BIT/2 resample;
//   if 1 -> false start, back to IDLE, no byte. DATA: sample each CLKS_PER_BIT, 8
//   bits LSB first. STOP: sample at CLKS_PER_BIT; 1 -> rx_valid pulse (1 cycle) with
//   byte; 0 -> framing error. Next start edge accepted immediately after STOP.
//  Loader FSM (advances only on rx_valid or error):
//   LEN_LO: len[7:0]. LEN_HI: len[15:8]; then len==0 -> SUM; len > 2**ADDR_W -> ERROR;
//   else DATA.
//   DATA: bytes shift into word, byte0 -> [7:0] .. byte3 -> [31:24]; sum += byte (8-bit
//   wrap). After 4th byte: next cycle ram_we=1 for exactly one cycle, ram_wdata=word,
//   ram_addr=word index (0,1,2..). After len words -> SUM.
//   SUM: received byte == sum -> DONE, else ERROR.
//   DONE: boot_done=1, core_hold=0 from the cycle after the checksum stop sample;
//   all further UART traffic ignored, no more writes.
//   ERROR: boot_err=1, core_hold stays 1, no writes; exit only via reset.
//  Framing error in any loader state other than DONE -> ERROR.
//  Length bytes and checksum byte are not included in sum.
//  Reset mid-image: FSMs restart at LEN_LO; words already written are not undone.
//  ram_addr holds last written address between strobes; ram_we never high 2 cycles.
// TESTING  (bench uses CLKS_PER_BIT=8, ADDR_W=4)
//  1 reset asserted 3 cycles, uart_rx=1 -> ram_we=0, core_hold=1, done=0, err=0.
//  2 bytes 02 00 13 00 00 00 93 00 10 00 B6 -> ram_we @addr0 data 0x00000013, @addr1
//    0x00100093; then boot_done=1, core_hold=0, boot_err=0.
//  3 as test 2 but checksum 00 -> two writes occur, boot_err=1, core_hold=1, done=0.
//  4 stop bit driven 0 on first byte -> boot_err=1, no ram_we ever.
//  5 uart_rx low for 2 cycles then high -> no byte; then test 2 stream passes normally.
//  6 length 11 00 (17 > 16) -> boot_err=1, no write; reset mid-DATA after 1 word, then
//    full test 2 stream -> boot_done=1, writes restart at addr 0.

Source files
------------

// File: rtl/rv32i_uart_boot_loader.sv
// UART (8N1) program-image loader: receives a length-prefixed, checksummed image and
// writes it word-by-word into RAM, holding the core in reset until the image is verified.
module rv32i_uart_boot_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              core_hold,
  output logic              boot_done,
  output logic              boot_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]  WCNT_ONE = (ADDR_W+1)'(1);
  localparam logic [16:0]      CAP      = 17'(1) << ADDR_W;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] LD_LEN_LO = 3'd0;
  localparam logic [2:0] LD_LEN_HI = 3'd1;
  localparam logic [2:0] LD_DATA   = 3'd2;
  localparam logic [2:0] LD_SUM    = 3'd3;
  localparam logic [2:0] LD_DONE   = 3'd4;
  localparam logic [2:0] LD_ERROR  = 3'd5;

  logic [1:0]        sync_q, sync_d;
  logic              rx_prev_q, rx_prev_d;
  logic [1:0]        rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;

  logic [2:0]        ld_state_q, ld_state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        sum_q, sum_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;

  logic              rx_s;
  logic              rx_valid;
  logic              frm_err;
  logic [7:0]        rx_byte;
  logic [16:0]       len17;
  logic [31:0]       word_next;

  assign rx_s      = sync_q[1];
  assign sync_d    = {sync_q[0], uart_rx};
  assign rx_prev_d = rx_s;
  assign rx_byte   = shift_q;
  assign len17     = {1'b0, rx_byte, len_lo_q};
  assign word_next = {rx_byte, word_q[31:8]};

  // Receiver: start bit re-checked at mid-bit, then every bit sampled one bit period later.
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_valid   = 1'b0;
    frm_err    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d      = '0;
          bit_d      = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d      = '0;
          rx_state_d = RX_IDLE;
          rx_valid   = rx_s;
          frm_err    = !rx_s;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // Loader: length (LE 16-bit), len words of data, then an 8-bit wrapping checksum of data bytes.
  always_comb begin
    ld_state_d  = ld_state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    sum_d       = sum_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (ld_state_q)
      LD_LEN_LO: begin
        if (rx_valid) begin
          len_lo_d   = rx_byte;
          ld_state_d = LD_LEN_HI;
        end
      end
      LD_LEN_HI: begin
        if (rx_valid) begin
          if (len17 == 17'd0) begin
            ld_state_d = LD_SUM;
          end else if (len17 > CAP) begin
            ld_state_d = LD_ERROR;
          end else begin
            len_d      = len17[ADDR_W:0];
            ld_state_d = LD_DATA;
          end
        end
      end
      LD_DATA: begin
        if (rx_valid) begin
          sum_d      = sum_q + rx_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          word_d     = word_next;
          if (byte_idx_q == 2'd3) begin
            ram_we_d    = 1'b1;
            ram_wdata_d = word_next;
            ram_addr_d  = word_cnt_q[ADDR_W-1:0];
            word_cnt_d  = word_cnt_q + WCNT_ONE;
            if ((word_cnt_q + WCNT_ONE) == len_q) ld_state_d = LD_SUM;
          end
        end
      end
      LD_SUM: begin
        if (rx_valid) ld_state_d = (rx_byte == sum_q) ? LD_DONE : LD_ERROR;
      end
      default: ;
    endcase
    if (frm_err && ld_state_q != LD_DONE) ld_state_d = LD_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= 2'b11;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      ld_state_q  <= LD_LEN_LO;
      len_lo_q    <= '0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      sum_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      sync_q      <= sync_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      ld_state_q  <= ld_state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      sum_q       <= sum_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign boot_done = (ld_state_q == LD_DONE);
  assign boot_err  = (ld_state_q == LD_ERROR);
  assign core_hold = !boot_done;

endmodule

// File: tb/tb_rv32i_uart_boot_loader.sv
// Directed bench for the UART boot loader: expected RAM writes are queued when a stream
// is sent and checked as the loader strobes ram_we; status outputs checked after each stream.
module tb_rv32i_uart_boot_loader;
  localparam int CPB    = 8;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              uart_rx = 1'b1;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              core_hold, boot_done, boot_err;

  int checks = 0;
  int passed = 0;
  logic [35:0] exp_q[$];
  logic        prev_we = 1'b0;

  rv32i_uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .core_hold(core_hold), .boot_done(boot_done), .boot_err(boot_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
      $error("%s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && ram_we) begin
      chk("we_two_cycles", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {28'd0, ram_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        chk("write_addr", {28'd0, ram_addr}, {28'd0, e[35:32]});
        chk("write_data", ram_wdata, e[31:0]);
      end
    end
    prev_we = ram_we;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    uart_rx = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      cycles(CPB);
    end
    uart_rx = stop_bit;
    cycles(CPB);
    uart_rx = 1'b1;
    cycles(2);
  endtask

  task automatic send_image(input logic [7:0] cks);
    logic [7:0] img[10];
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    exp_q.push_back({4'd0, 32'h0000_0013});
    exp_q.push_back({4'd1, 32'h0010_0093});
    for (int i = 0; i < 10; i++) send_byte(img[i], 1'b1);
    send_byte(cks, 1'b1);
    cycles(4);
  endtask

  task automatic status(input string t, input logic we, input logic hold, input logic done, input logic err);
    chk({t, "_ram_we"}, {31'd0, ram_we}, {31'd0, we});
    chk({t, "_core_hold"}, {31'd0, core_hold}, {31'd0, hold});
    chk({t, "_boot_done"}, {31'd0, boot_done}, {31'd0, done});
    chk({t, "_boot_err"}, {31'd0, boot_err}, {31'd0, err});
    chk({t, "_pending_writes"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    // 1: reset state
    reset = 1'b1;
    cycles(3);
    status("t1", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1_ram_addr", {28'd0, ram_addr}, 32'd0);
    chk("t1_ram_wdata", ram_wdata, 32'd0);
    reset = 1'b0;
    cycles(2);

    // 2: good image
    send_image(8'hB6);
    status("t2", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_addr_held", {28'd0, ram_addr}, 32'd1);
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b0);
    cycles(4);
    status("t2_ignored", 1'b0, 1'b0, 1'b1, 1'b0);

    // 3: bad checksum
    do_reset();
    send_image(8'h00);
    status("t3", 1'b0, 1'b1, 1'b0, 1'b1);

    // 4: framing error on first byte
    do_reset();
    send_byte(8'h02, 1'b0);
    cycles(4);
    status("t4", 1'b0, 1'b1, 1'b0, 1'b1);

    // 5: glitch then good image
    do_reset();
    uart_rx = 1'b0;
    cycles(2);
    uart_rx = 1'b1;
    cycles(20);
    send_image(8'hB6);
    status("t5", 1'b0, 1'b0, 1'b1, 1'b0);

    // 6: oversize length, then reset mid-image, then good image
    do_reset();
    send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b1);
    cycles(4);
    status("t6_len", 1'b0, 1'b1, 1'b0, 1'b1);
    do_reset();
    exp_q.push_back({4'd0, 32'h0000_0013});
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    cycles(4);
    status("t6_partial", 1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();
    send_image(8'hB6);
    status("t6", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
